// File: rtl/text_line_arbiter.sv
// text_line_arbiter: shared-write controller for the VGA text character buffer.
// Two line-write requesters and a whole-buffer clear compete for one buffer.
// Grants are round-robin between A and B, and the clear always wins. Every
// buffer update waits until the raster is outside the text band.
//
// Handshake: a requester raises req (or clr_req) with its row and line stable
// and holds it level. The block samples requests only in IDLE; the matching
// ack (ack_a, ack_b, clr_ack) pulses for exactly one cycle in HOLD, and the
// requester drops req on the edge that ends HOLD. A req still high in IDLE is
// taken as a new request. err_a/err_b pulse with the ack when the row was out
// of range, in which case the buffer is left untouched.
module text_line_arbiter #(
   parameter int         NUM_LINES  = 12,
   parameter int         SAFE_LO    = 60,
   parameter int         SAFE_HI    = 515,
   parameter logic [6:0] BLANK_CHAR = 7'h20
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [9:0]               ve_counter,
   input  logic                     req_a,
   input  logic [3:0]               row_a,
   input  logic [62:0]              line_a,
   output logic                     ack_a,
   output logic                     err_a,
   input  logic                     req_b,
   input  logic [3:0]               row_b,
   input  logic [62:0]              line_b,
   output logic                     ack_b,
   output logic                     err_b,
   input  logic                     clr_req,
   output logic                     clr_ack,
   output logic [NUM_LINES*63-1:0]  words,
   output logic                     busy
);

   localparam int         WW          = NUM_LINES * 63;
   localparam int         NCHARS      = NUM_LINES * 9;
   localparam logic [4:0] NUM_LINES_V = 5'(NUM_LINES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;
   typedef enum logic [1:0] {SRC_A, SRC_B, SRC_CLR}     src_t;

   state_t       state;
   state_t       next_state;
   src_t         src_q;
   logic [3:0]   row_q;
   logic [62:0]  line_q;
   logic         err_q;
   logic         last_b;      // 1 when B holds the most recent A/B grant

   logic         safe;
   logic         grant;
   src_t         grant_src;
   logic [3:0]   grant_row;
   logic [62:0]  grant_line;
   logic         grant_bad;
   logic         commit;

   assign safe = (ve_counter < 10'(SAFE_LO)) || (ve_counter > 10'(SAFE_HI));

   // Request selection: clear first, then round-robin between A and B.
   always_comb begin
      grant      = 1'b0;
      grant_src  = SRC_A;
      grant_row  = row_a;
      grant_line = line_a;
      if (clr_req) begin
         grant      = 1'b1;
         grant_src  = SRC_CLR;
         grant_row  = '0;
         grant_line = '0;
      end else if (req_a && (!req_b || last_b)) begin
         grant = 1'b1;
      end else if (req_b) begin
         grant      = 1'b1;
         grant_src  = SRC_B;
         grant_row  = row_b;
         grant_line = line_b;
      end
   end

   // A clear has no row, so it can never be out of range.
   assign grant_bad = (grant_src != SRC_CLR) && ({1'b0, grant_row} >= NUM_LINES_V);

   // Next-state logic; commit marks the single WAIT cycle that updates words.
   always_comb begin
      next_state = state;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant) begin
               next_state = grant_bad ? ST_HOLD : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (safe) begin
               commit     = 1'b1;
               next_state = ST_HOLD;
            end
         end
         ST_HOLD: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // State register and grant latches; inputs are captured only on an IDLE grant.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         src_q  <= SRC_A;
         row_q  <= '0;
         line_q <= '0;
         err_q  <= 1'b0;
         last_b <= 1'b1;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && grant) begin
            src_q  <= grant_src;
            row_q  <= grant_row;
            line_q <= grant_line;
            err_q  <= grant_bad;
            if (grant_src != SRC_CLR) begin
               last_b <= (grant_src == SRC_B);
            end
         end
      end
   end

   // Character buffer: blank on reset, changed only on a WAIT commit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         words <= {NCHARS{BLANK_CHAR}};
      end else if (commit) begin
         if (src_q == SRC_CLR) begin
            words <= {NCHARS{BLANK_CHAR}};
         end else begin
            for (int r = 0; r < NUM_LINES; r++) begin
               if (row_q == 4'(r)) begin
                  words[WW-1-63*r -: 63] <= line_q;
               end
            end
         end
      end
   end

   assign busy    = (state != ST_IDLE);
   assign ack_a   = (state == ST_HOLD) && (src_q == SRC_A);
   assign ack_b   = (state == ST_HOLD) && (src_q == SRC_B);
   assign clr_ack = (state == ST_HOLD) && (src_q == SRC_CLR);
   assign err_a   = ack_a && err_q;
   assign err_b   = ack_b && err_q;

endmodule

// File: tb/tb_text_line_arbiter.sv
// tb_text_line_arbiter: directed bench for text_line_arbiter with
// hand-computed expected buffer contents and grant order.
module tb_text_line_arbiter;

   localparam logic [2:0] CODE_A   = 3'b001;
   localparam logic [2:0] CODE_B   = 3'b010;
   localparam logic [2:0] CODE_CLR = 3'b100;

   logic          CLK;
   logic          RST;
   logic [9:0]    ve_counter;
   logic          req_a;
   logic [3:0]    row_a;
   logic [62:0]   line_a;
   logic          ack_a;
   logic          err_a;
   logic          req_b;
   logic [3:0]    row_b;
   logic [62:0]   line_b;
   logic          ack_b;
   logic          err_b;
   logic          clr_req;
   logic          clr_ack;
   logic [755:0]  words;
   logic          busy;

   logic [755:0]  blank;
   logic [755:0]  exp_words;
   logic [2:0]    exp_q[$];
   int            checks;
   int            errors;

   text_line_arbiter dut (
      .CLK        (CLK),
      .RST        (RST),
      .ve_counter (ve_counter),
      .req_a      (req_a),
      .row_a      (row_a),
      .line_a     (line_a),
      .ack_a      (ack_a),
      .err_a      (err_a),
      .req_b      (req_b),
      .row_b      (row_b),
      .line_b     (line_b),
      .ack_b      (ack_b),
      .err_b      (err_b),
      .clr_req    (clr_req),
      .clr_ack    (clr_ack),
      .words      (words),
      .busy       (busy)
   );

   // Clock generation.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [755:0] got, input logic [755:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic put_line(input logic [3:0] r, input logic [62:0] v);
      exp_words[755 - 63*r -: 63] = v;
   endtask

   // Wait (bounded) for any acknowledge; got = {clr_ack, ack_b, ack_a}.
   task automatic wait_ack(input string tag, output logic [2:0] got);
      int n;
      got = 3'b000;
      n   = 0;
      while (got == 3'b000 && n < 12) begin
         step();
         got = {clr_ack, ack_b, ack_a};
         n++;
      end
      check({tag, "_seen"}, 756'(got != 3'b000), 756'(1));
   endtask

   // Serve the next expected grant: check which ack fired and the buffer.
   task automatic serve(input string tag);
      logic [2:0] exp_code;
      logic [2:0] got;
      exp_code = exp_q.pop_front();
      wait_ack(tag, got);
      check({tag, "_ack"}, 756'(got), 756'(exp_code));
      if (exp_code == CODE_CLR) exp_words = blank;
      else if (exp_code == CODE_A) put_line(row_a, line_a);
      else put_line(row_b, line_b);
      check({tag, "_words"}, words, exp_words);
      if (got[0]) req_a = 1'b0;
      if (got[1]) req_b = 1'b0;
      if (got[2]) clr_req = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check(tag, 756'({busy, clr_ack, ack_b, ack_a, err_b, err_a}), 756'(0));
   endtask

   // Directed stimulus.
   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 108; i++) blank[i*7 +: 7] = 7'h20;
      exp_words  = blank;
      RST        = 1'b1;
      ve_counter = '0;
      req_a      = 1'b0;
      row_a      = '0;
      line_a     = '0;
      req_b      = 1'b0;
      row_b      = '0;
      line_b     = '0;
      clr_req    = 1'b0;

      // Reset.
      repeat (2) step();
      check("rst_words", words, blank);
      check_quiet("rst_outs");
      RST = 1'b0;
      step();

      // Immediate write: ack two cycles after the IDLE sample.
      ve_counter = 10'd520;
      req_a      = 1'b1;
      row_a      = 4'd0;
      line_a     = 63'h0123456789ABCDE;
      step();
      check("imm_wait_busy", 756'({busy, ack_a}), 756'(2'b10));
      step();
      check("imm_ack", 756'({ack_a, err_a}), 756'(2'b10));
      put_line(4'd0, 63'h0123456789ABCDE);
      check("imm_words", words, exp_words);
      req_a = 1'b0;
      step();
      check_quiet("imm_idle");

      // Deferred write: held through the band, commit when ve reaches 516.
      ve_counter = 10'd200;
      req_b      = 1'b1;
      row_b      = 4'd11;
      line_b     = 63'h7EDCBA9876543210;
      step();
      check("def_busy0", 756'({busy, ack_b}), 756'(2'b10));
      row_b      = 4'd3;
      line_b     = '1;
      ve_counter = 10'd515;
      step();
      check("def_busy515", 756'({busy, ack_b}), 756'(2'b10));
      check("def_words515", words, exp_words);
      ve_counter = 10'd60;
      step();
      check("def_busy60", 756'({busy, ack_b}), 756'(2'b10));
      check("def_words60", words, exp_words);
      ve_counter = 10'd516;
      step();
      check("def_ack", 756'({ack_b, err_b}), 756'(2'b10));
      put_line(4'd11, 63'h7EDCBA9876543210);
      check("def_words", words, exp_words);
      req_b      = 1'b0;
      ve_counter = 10'd0;
      step();
      check_quiet("def_idle");

      // Round-robin right after a reset: A wins the first tie.
      RST = 1'b1;
      step();
      RST       = 1'b0;
      exp_words = blank;
      check("rr_rst_words", words, exp_words);
      ve_counter = 10'd0;
      req_a  = 1'b1; row_a = 4'd1; line_a = 63'h1111111111111111;
      req_b  = 1'b1; row_b = 4'd2; line_b = 63'h2222222222222222;
      exp_q.push_back(CODE_A);
      exp_q.push_back(CODE_B);
      serve("rr1_a");
      serve("rr1_b");
      // Lone A at the last safe line before the band.
      step();
      ve_counter = 10'd59;
      req_a  = 1'b1; row_a = 4'd3; line_a = 63'h3333333333333333;
      exp_q.push_back(CODE_A);
      serve("rr_lone_a");
      step();
      req_a  = 1'b1; row_a = 4'd4; line_a = 63'h4444444444444444;
      req_b  = 1'b1; row_b = 4'd9; line_b = 63'h0999999999999999;
      exp_q.push_back(CODE_B);
      exp_q.push_back(CODE_A);
      serve("rr2_b");
      serve("rr2_a");

      // Clear priority over a pending line write.
      step();
      ve_counter = 10'd0;
      clr_req = 1'b1;
      req_b   = 1'b1; row_b = 4'd5; line_b = 63'h5555555555555555;
      exp_q.push_back(CODE_CLR);
      exp_q.push_back(CODE_B);
      serve("clr1_c");
      serve("clr1_b");
      // Clear, A and B together with B granted last.
      step();
      clr_req = 1'b1;
      req_a   = 1'b1; row_a = 4'd7; line_a = 63'h0777777777777777;
      req_b   = 1'b1; row_b = 4'd8; line_b = 63'h0888888888888888;
      exp_q.push_back(CODE_CLR);
      exp_q.push_back(CODE_A);
      exp_q.push_back(CODE_B);
      serve("clr2_c");
      serve("clr2_a");
      serve("clr2_b");

      // Out-of-range rows: ack and err one cycle after the sample.
      step();
      ve_counter = 10'd200;
      req_a = 1'b1; row_a = 4'd12; line_a = '1;
      step();
      check("err_a", 756'({ack_a, err_a, busy}), 756'(3'b111));
      check("err_a_words", words, exp_words);
      req_a = 1'b0;
      step();
      check_quiet("err_a_idle");
      req_b = 1'b1; row_b = 4'd15; line_b = '1;
      step();
      check("err_b", 756'({ack_b, err_b, ack_a, err_a}), 756'(4'b1100));
      check("err_b_words", words, exp_words);
      req_b = 1'b0;
      step();

      // Reset while parked in WAIT: no ack, buffer blank, request re-served.
      req_b = 1'b1; row_b = 4'd4; line_b = 63'h0ABCDEF012345678;
      step();
      check("abort_wait", 756'({busy, ack_b}), 756'(2'b10));
      RST = 1'b1;
      step();
      exp_words = blank;
      check_quiet("abort_outs");
      check("abort_words", words, exp_words);
      RST        = 1'b0;
      ve_counter = 10'd0;
      exp_q.push_back(CODE_B);
      serve("abort_reserve");
      step();
      check_quiet("final_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
